// File: rtl/alu_issue_sequencer.sv
// Shares one multi-cycle ALU between two requesters: round-robin grant, fixed-latency
// issue, flag derivation and a valid/ready response; also owns the architectural flags.
module alu_issue_sequencer #(
   parameter int WORD_SIZE   = 19,
   parameter int OP_W        = 5,
   parameter int ALU_LATENCY = 1,
   parameter int FLAG_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [OP_W-1:0]      req0_op,
   input  logic                 req0_mode,
   input  logic [WORD_SIZE-1:0] req0_a,
   input  logic [WORD_SIZE-1:0] req0_b,
   input  logic                 req0_flag_we,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [OP_W-1:0]      req1_op,
   input  logic                 req1_mode,
   input  logic [WORD_SIZE-1:0] req1_a,
   input  logic [WORD_SIZE-1:0] req1_b,
   input  logic                 req1_flag_we,
   output logic [OP_W-1:0]      alu_op,
   output logic                 alu_mode,
   output logic [WORD_SIZE-1:0] alu_a,
   output logic [WORD_SIZE-1:0] alu_b,
   input  logic [WORD_SIZE-1:0] alu_result,
   input  logic                 alu_carry,
   input  logic                 alu_ovf,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [WORD_SIZE-1:0] rsp_result,
   output logic [FLAG_W-1:0]    rsp_flags,
   output logic [FLAG_W-1:0]    flags
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

   logic [1:0]        state;
   logic [1:0]        cnt;
   logic              ptr;
   logic              id_q;
   logic              we_q;
   logic              gnt0, gnt1;
   logic [FLAG_W-1:0] cap_flags;

   // Contention goes to the pointer port; a lone requester always wins.
   assign gnt0 = req0_valid & (~req1_valid | ~ptr);
   assign gnt1 = req1_valid & (~req0_valid |  ptr);

   assign req0_ready = (state == S_IDLE) & ~flush & gnt0;
   assign req1_ready = (state == S_IDLE) & ~flush & gnt1;
   assign rsp_valid  = (state == S_RESP);

   // Carry/overflow are meaningless for logical ops, so they never reach the flags.
   always_comb begin
      cap_flags    = '0;
      cap_flags[0] = (alu_result == '0);
      cap_flags[1] = alu_result[WORD_SIZE-1];
      cap_flags[2] = ~alu_mode & alu_carry;
      cap_flags[3] = ~alu_mode & alu_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         ptr        <= 1'b0;
         id_q       <= 1'b0;
         we_q       <= 1'b0;
         alu_op     <= '0;
         alu_mode   <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         flags      <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (req0_ready || req1_ready) begin
                  alu_op   <= req1_ready ? req1_op      : req0_op;
                  alu_mode <= req1_ready ? req1_mode    : req0_mode;
                  alu_a    <= req1_ready ? req1_a       : req0_a;
                  alu_b    <= req1_ready ? req1_b       : req0_b;
                  we_q     <= req1_ready ? req1_flag_we : req0_flag_we;
                  id_q     <= req1_ready;
                  ptr      <= ~req1_ready;
                  cnt      <= CNT_INIT;
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt == '0) begin
                  rsp_result <= alu_result;
                  rsp_flags  <= cap_flags;
                  rsp_id     <= id_q;
                  state      <= S_RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  if (we_q) flags <= rsp_flags;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: directed literal checks plus random traffic, all
// compared every cycle against a transaction-level model of the sequencer.
module tb_alu_issue_sequencer;
   localparam int W = 19, OPW = 5, L = 3, FW = 4;

   logic clk, rst_n, flush;
   logic req0_valid, req0_ready, req0_mode, req0_flag_we;
   logic req1_valid, req1_ready, req1_mode, req1_flag_we;
   logic [OPW-1:0] req0_op, req1_op, alu_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
   logic alu_mode, alu_carry, alu_ovf, rsp_valid, rsp_ready, rsp_id;
   logic [FW-1:0] rsp_flags, flags;

   alu_issue_sequencer #(.WORD_SIZE(W), .OP_W(OPW), .ALU_LATENCY(L), .FLAG_W(FW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_mode(req0_mode),
      .req0_a(req0_a), .req0_b(req0_b), .req0_flag_we(req0_flag_we),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_mode(req1_mode),
      .req1_a(req1_a), .req1_b(req1_b), .req1_flag_we(req1_flag_we),
      .alu_op(alu_op), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags(flags));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {ovf, carry, result}. Logical ops report a junk carry/ovf on purpose.
   function automatic logic [W+1:0] alu_f(input logic [OPW-1:0] op, input logic mode,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      logic ov;
      if (!mode) begin
         if (!op[0]) begin
            s  = {1'b0, a} + {1'b0, b};
            ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
         end else begin
            s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
         end
         return {ov, s};
      end
      return {op[1], 1'b1, (op[0] ? (a ^ b) : (a & b))};
   endfunction

   function automatic logic [3:0] exp_flags(input logic [W+1:0] r, input logic mode);
      return {~mode & r[W+1], ~mode & r[W], r[W-1], r[W-1:0] == '0};
   endfunction

   // ALU stand-in with true latency: result reflects operands from L-1 cycles ago.
   logic [OPW+2*W:0] d0, d1, d2;
   assign d0 = {alu_op, alu_mode, alu_a, alu_b};
   always @(posedge clk) begin
      d1 <= d0;
      d2 <= d1;
   end
   assign {alu_ovf, alu_carry, alu_result} =
      alu_f(d2[OPW+2*W:2*W+1], d2[2*W], d2[2*W-1:W], d2[W-1:0]);

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one operation in flight, L cycles of issue then a held response.
   typedef struct {
      logic id; logic [OPW-1:0] op; logic mode; logic [W-1:0] a, b; logic we;
   } txn_t;
   bit   m_busy, m_ptr;
   int   m_left;
   txn_t m_cur;
   logic [FW-1:0] m_flags;

   always @(negedge clk) begin : model
      int g;
      logic [W+1:0] r;
      bit idle, inresp;
      if (!rst_n) begin
         m_busy = 0; m_ptr = 0; m_left = 0; m_flags = '0;
      end else begin
         g = -1;
         if (req0_valid && (!req1_valid || !m_ptr)) g = 0;
         else if (req1_valid) g = 1;
         idle   = !m_busy;
         inresp = m_busy && (m_left == 0);
         chk("m_ready0", req0_ready, idle && !flush && g == 0);
         chk("m_ready1", req1_ready, idle && !flush && g == 1);
         chk("m_rsp_valid", rsp_valid, inresp);
         chk("m_flags", flags, m_flags);
         if (m_busy && m_left > 0) begin
            chk("m_alu_opnds", {alu_op, alu_mode, alu_a, alu_b}, {m_cur.op, m_cur.mode, m_cur.a, m_cur.b});
         end
         if (inresp) begin
            r = alu_f(m_cur.op, m_cur.mode, m_cur.a, m_cur.b);
            chk("m_rsp_id", rsp_id, m_cur.id);
            chk("m_rsp_result", rsp_result, r[W-1:0]);
            chk("m_rsp_flags", rsp_flags, exp_flags(r, m_cur.mode));
         end
         if (flush) m_busy = 0;
         else if (idle) begin
            if (g == 0) m_cur = '{1'b0, req0_op, req0_mode, req0_a, req0_b, req0_flag_we};
            if (g == 1) m_cur = '{1'b1, req1_op, req1_mode, req1_a, req1_b, req1_flag_we};
            if (g >= 0) begin m_busy = 1; m_left = L; m_ptr = (g == 0); end
         end else if (m_left > 0) m_left--;
         else if (rsp_ready) begin
            if (m_cur.we) m_flags = exp_flags(r, m_cur.mode);
            m_busy = 0;
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask

   task automatic issue(input bit p, input logic [OPW-1:0] op, input logic mode,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic we);
      bit got = 0;
      tick();
      if (p) begin req1_op = op; req1_mode = mode; req1_a = a; req1_b = b; req1_flag_we = we; req1_valid = 1; end
      else   begin req0_op = op; req0_mode = mode; req0_a = a; req0_b = b; req0_flag_we = we; req0_valid = 1; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = p ? req1_ready : req0_ready;
      end
      if (!got) chk("issue_timeout", 0, 1);
      tick();
      if (p) req1_valid = 0; else req0_valid = 0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < 30);
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
   endtask

   task automatic take_rsp();
      tick(); rsp_ready = 1;
      tick(); rsp_ready = 0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int c;
      int ng;
      logic [2:0] gl;
      bit prev, dbl, acc0, acc1;
      logic [W-1:0] held;
      rst_n = 0; flush = 0; rsp_ready = 0;
      req0_valid = 0; req0_op = '0; req0_mode = 0; req0_a = '0; req0_b = '0; req0_flag_we = 0;
      req1_valid = 0; req1_op = '0; req1_mode = 0; req1_a = '0; req1_b = '0; req1_flag_we = 0;
      #2;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_flags", flags, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_rsp_result", rsp_result, 0);
      repeat (2) tick();
      rst_n = 1;

      // Single add: 5 + 3
      issue(0, 5'd0, 0, 19'h00005, 19'h00003, 1);
      wait_rsp(c);
      chk("t1_latency", c, L + 1);
      chk("t1_id", rsp_id, 0);
      chk("t1_result", rsp_result, 19'd8);
      chk("t1_rflags", rsp_flags, 4'b0000);
      take_rsp();
      chk("t1_flags", flags, 4'b0000);

      // Both ports contending from reset: grants must alternate 0, 1, 0
      tick(); rst_n = 0;
      @(negedge clk);
      tick(); rst_n = 1;
      rsp_ready = 1; req0_valid = 1; req1_valid = 1;
      ng = 0; gl = '0; prev = 0; dbl = 0;
      for (int i = 0; i < 60 && ng < 3; i++) begin
         @(negedge clk);
         if ((req0_ready || req1_ready) && prev) dbl = 1;
         prev = req0_ready || req1_ready;
         if (req0_ready && req1_ready) dbl = 1;
         else if (req0_ready) begin gl[ng] = 0; ng++; end
         else if (req1_ready) begin gl[ng] = 1; ng++; end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      chk("arb_count", ng, 3);
      chk("arb_order", gl, 3'b010);
      chk("arb_single_cycle", dbl, 0);
      repeat (L + 3) tick();
      rsp_ready = 0;

      // Flag derivation and commit gating
      issue(0, 5'd0, 0, 19'h7FFFF, 19'h40001, 1);
      wait_rsp(c);
      chk("t3_result", rsp_result, 19'h40000);
      chk("t3_rflags", rsp_flags, 4'b0110);
      take_rsp();
      chk("t3_flags", flags, 4'b0110);
      issue(1, 5'd0, 1, 19'h00F0F, 19'h070F0, 0);
      wait_rsp(c);
      chk("t3b_rflags", rsp_flags, 4'b0001);
      take_rsp();
      chk("t3b_flags", flags, 4'b0110);

      // Response back-pressure with a competing request pending
      issue(0, 5'd1, 0, 19'd9, 19'd2, 0);
      wait_rsp(c);
      held = rsp_result;
      chk("t4_result", held, 19'd7);
      tick(); req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold", {rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready}, {1'b1, 1'b0, held, 2'b00});
      end
      tick(); rsp_ready = 1;
      tick(); rsp_ready = 0;
      @(negedge clk);
      chk("t4_done", rsp_valid, 0);
      tick(); req1_valid = 0;
      wait_rsp(c);
      take_rsp();

      // Flush in the second issue cycle: nothing committed, pointer keeps the original grant
      issue(0, 5'd0, 0, 19'd0, 19'd0, 1);
      tick(); flush = 1;
      tick(); flush = 0; req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 0);
      chk("t5_grant", {req0_ready, req1_ready}, 2'b01);
      chk("t5_flags", flags, 4'b0110);
      tick(); req0_valid = 0; req1_valid = 0;
      wait_rsp(c);
      take_rsp();

      // Asynchronous reset while a response is pending
      issue(0, 5'd0, 0, 19'd1, 19'd1, 0);
      wait_rsp(c);
      #1 rst_n = 0;
      #1;
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_flags", flags, 0);
      tick();
      tick(); rst_n = 1; req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      chk("t6_grant", {req0_ready, req1_ready}, 2'b10);
      tick(); req0_valid = 0; req1_valid = 0;
      wait_rsp(c);
      take_rsp();

      // Random traffic; the model process does the checking
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         tick();
         if (acc0) req0_valid = 0;
         if (acc1) req1_valid = 0;
         if (!req0_valid && $urandom_range(0, 2) == 0) begin
            req0_op = OPW'($urandom); req0_mode = 1'($urandom); req0_flag_we = 1'($urandom);
            req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1;
         end
         if (!req1_valid && $urandom_range(0, 2) == 0) begin
            req1_op = OPW'($urandom); req1_mode = 1'($urandom); req1_flag_we = 1'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
      end
      tick();
      req0_valid = 0; req1_valid = 0; flush = 0; rsp_ready = 1;
      repeat (L + 4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
